data_merge: RTL and testbench

DATA_MERGE -- requirements
Module: data_merge

---
 rtl/data_bus_pkg.sv | 22 ++
 rtl/chan_fifo.sv | 56 +++++
 rtl/data_merge.sv | 127 ++++++++++++
 tb/tb_data_merge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared definitions for the two-channel merge onto the tagged 8-bit strobe bus.
// Holds payload width, channel tags and the output sequencer state encoding.
package data_bus_pkg;

  localparam int PAYLOAD_W = 7;
  localparam int WORD_W    = PAYLOAD_W + 1;

  localparam logic TAG_A = 1'b1;
  localparam logic TAG_B = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] tag_word(input logic tag,
                                                 input logic [PAYLOAD_W-1:0] payload);
    return {tag, payload};
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel word buffer; head word visible combinationally, write lands one edge after accept.
// Push is ignored while full and pop is ignored while empty; push+pop together keep occupancy.
module chan_fifo
  import data_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [PAYLOAD_W-1:0] i_data,
  input  logic                 i_pop,
  output logic [PAYLOAD_W-1:0] o_data,
  output logic                 o_empty,
  output logic                 o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PAYLOAD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/data_merge.sv
// Merges channels A and B onto a tagged strobe bus, round-robin, one strobe then GAP idle cycles.
// Word accepted on edge k strobes after edge k+1; x_ready drops only when that channel's buffer is full.
module data_merge
  import data_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PAYLOAD_W-1:0] a_data,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [PAYLOAD_W-1:0] b_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  output logic [WORD_W-1:0]    DATA,
  output logic                 data_sb,
  output logic                 busy
);

  localparam int GW = $clog2(GAP + 1);

  state_t               r_state;
  state_t               w_next;
  logic [GW-1:0]        r_gap_cnt;
  logic [WORD_W-1:0]    r_data;
  logic                 r_last_a;

  logic [PAYLOAD_W-1:0] w_head_a;
  logic [PAYLOAD_W-1:0] w_head_b;
  logic                 w_empty_a;
  logic                 w_empty_b;
  logic                 w_full_a;
  logic                 w_full_b;
  logic                 w_pop_a;
  logic                 w_pop_b;
  logic                 w_any;
  logic                 w_pick_a;
  logic                 w_launch;

  chan_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .i_push  (a_valid),
    .i_data  (a_data),
    .i_pop   (w_pop_a),
    .o_data  (w_head_a),
    .o_empty (w_empty_a),
    .o_full  (w_full_a)
  );

  chan_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .i_push  (b_valid),
    .i_data  (b_data),
    .i_pop   (w_pop_b),
    .o_data  (w_head_b),
    .o_empty (w_empty_b),
    .o_full  (w_full_b)
  );

  assign a_ready  = !w_full_a;
  assign b_ready  = !w_full_b;
  assign w_any    = !w_empty_a || !w_empty_b;
  // A wins when it is the only candidate or when B was granted last.
  assign w_pick_a = !w_empty_a && (w_empty_b || !r_last_a);

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_launch = 1'b1;
          w_next   = S_STROBE;
        end
      end
      S_STROBE: begin
        w_next = S_GAP;
      end
      S_GAP: begin
        // Launching straight from the last gap cycle keeps back-to-back spacing at exactly GAP.
        if (r_gap_cnt <= GW'(1)) begin
          if (w_any) begin
            w_launch = 1'b1;
            w_next   = S_STROBE;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_pop_a = w_launch && w_pick_a;
  assign w_pop_b = w_launch && !w_pick_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
      r_data    <= '0;
      r_last_a  <= TAG_B;
    end else begin
      r_state <= w_next;
      if (r_state == S_STROBE) begin
        r_gap_cnt <= GW'(GAP);
      end else if (r_state == S_GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GW'(1);
      end
      if (w_launch) begin
        r_data   <= w_pick_a ? tag_word(TAG_A, w_head_a) : tag_word(TAG_B, w_head_b);
        r_last_a <= w_pick_a;
      end
    end
  end

  assign DATA    = r_data;
  assign data_sb = (r_state == S_STROBE);
  assign busy    = w_any || (r_state != S_IDLE);

endmodule

// File: tb/tb_data_merge.sv
// Bench for data_merge: a GAP=1 instance and a GAP=3 instance sharing clock and reset,
// each with a queue of expected bus words filled as stimulus is driven.
module tb_data_merge;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q1[$];
  logic [7:0] q3[$];

  logic [6:0] d1_a_data, d1_b_data, d3_a_data, d3_b_data;
  logic       d1_a_valid, d1_b_valid, d3_a_valid, d3_b_valid;
  logic       d1_a_ready, d1_b_ready, d3_a_ready, d3_b_ready;
  logic [7:0] d1_data, d3_data;
  logic       d1_sb, d3_sb, d1_busy, d3_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_merge #(.DEPTH(4), .GAP(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_data(d1_a_data), .a_valid(d1_a_valid), .a_ready(d1_a_ready),
    .b_data(d1_b_data), .b_valid(d1_b_valid), .b_ready(d1_b_ready),
    .DATA(d1_data), .data_sb(d1_sb), .busy(d1_busy)
  );

  data_merge #(.DEPTH(4), .GAP(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .a_data(d3_a_data), .a_valid(d3_a_valid), .a_ready(d3_a_ready),
    .b_data(d3_b_data), .b_valid(d3_b_valid), .b_ready(d3_b_ready),
    .DATA(d3_data), .data_sb(d3_sb), .busy(d3_busy)
  );

  task automatic wait_sb1(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (d1_sb === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (d1_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h want=00", d1_data); end
    n_cmp++; if (d1_sb !== 1'b0) begin n_bad++; $display("FAIL reset_sb got=%b want=0", d1_sb); end
    n_cmp++; if (d1_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", d1_busy); end
    n_cmp++; if ({d1_a_ready, d1_b_ready} !== 2'b11) begin n_bad++; $display("FAIL reset_ready_in got=%b want=11", {d1_a_ready, d1_b_ready}); end
    n_cmp++; if ({d3_a_ready, d3_b_ready} !== 2'b11) begin n_bad++; $display("FAIL reset_ready3_in got=%b want=11", {d3_a_ready, d3_b_ready}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({d1_a_ready, d1_b_ready} !== 2'b11) begin n_bad++; $display("FAIL reset_ready_after got=%b want=11", {d1_a_ready, d1_b_ready}); end
    n_cmp++; if ({d1_sb, d1_busy} !== 2'b00) begin n_bad++; $display("FAIL reset_idle_after got=%b want=00", {d1_sb, d1_busy}); end
  endtask

  task automatic test_single();
    logic [7:0] exp;
    bit         ok;
    int         at, k;
    @(posedge clk); #1;
    d1_a_data = 7'h15; d1_a_valid = 1'b1;
    q1.push_back(8'h95);
    @(posedge clk); #1;
    k = cyc;
    d1_a_valid = 1'b0;
    wait_sb1(10, ok, at);
    n_cmp++;
    if (!ok || q1.size() == 0) begin
      n_bad++; $display("FAIL single_data strobe_seen=%b queued=%0d want strobe", ok, q1.size());
    end else begin
      exp = q1.pop_front();
      if (d1_data !== exp) begin n_bad++; $display("FAIL single_data got=%h want=%h", d1_data, exp); end
    end
    n_cmp++; if (at !== k + 1) begin n_bad++; $display("FAIL single_latency got=%0d want=%0d", at, k + 1); end
    @(negedge clk);
    n_cmp++; if (d1_sb !== 1'b0) begin n_bad++; $display("FAIL single_sb_width got=%b want=0", d1_sb); end
    repeat (3) @(negedge clk);
    n_cmp++; if (d1_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_done got=%b want=0", d1_busy); end
    n_cmp++; if (d1_data !== 8'h95) begin n_bad++; $display("FAIL single_data_hold got=%h want=95", d1_data); end
  endtask

  task automatic test_rr();
    logic [7:0] exp;
    bit         ok1, ok2;
    int         c1, c2;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q1.delete();
    @(posedge clk); #1;
    d1_a_data = 7'h01; d1_b_data = 7'h02; d1_a_valid = 1'b1; d1_b_valid = 1'b1;
    q1.push_back(8'h81);
    q1.push_back(8'h02);
    @(posedge clk); #1;
    d1_a_valid = 1'b0; d1_b_valid = 1'b0;
    wait_sb1(10, ok1, c1);
    n_cmp++;
    if (!ok1 || q1.size() == 0) begin
      n_bad++; $display("FAIL rr_first strobe_seen=%b queued=%0d", ok1, q1.size());
    end else begin
      exp = q1.pop_front();
      if (d1_data !== exp) begin n_bad++; $display("FAIL rr_first got=%h want=%h", d1_data, exp); end
    end
    wait_sb1(10, ok2, c2);
    n_cmp++;
    if (!ok2 || q1.size() == 0) begin
      n_bad++; $display("FAIL rr_second strobe_seen=%b queued=%0d", ok2, q1.size());
    end else begin
      exp = q1.pop_front();
      if (d1_data !== exp) begin n_bad++; $display("FAIL rr_second got=%h want=%h", d1_data, exp); end
    end
    n_cmp++; if (c2 - c1 !== 2) begin n_bad++; $display("FAIL rr_spacing got=%0d want=2", c2 - c1); end
    repeat (3) @(negedge clk);
  endtask

  // GAP=3 instance: a B filler opens a long gap so both buffers can fill to DEPTH.
  task automatic test_fill();
    logic [7:0] exp;
    int         last_at, n_sb;
    bit         take;
    last_at = -1; n_sb = 0; take = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (d3_sb === 1'b1) begin
        n_cmp++;
        if (q3.size() == 0) begin
          n_bad++; $display("FAIL fill_data unexpected strobe got=%h want none", d3_data);
        end else begin
          exp = q3.pop_front();
          if (d3_data !== exp) begin n_bad++; $display("FAIL fill_data t=%0d got=%h want=%h", t, d3_data, exp); end
        end
        if (last_at >= 0) begin
          n_cmp++;
          if (t - last_at !== 4) begin n_bad++; $display("FAIL fill_spacing got=%0d want=4", t - last_at); end
        end
        last_at = t;
        n_sb++;
      end
      if (t == 5) begin
        n_cmp++;
        if ({d3_a_ready, d3_b_ready} !== 2'b00) begin n_bad++; $display("FAIL fill_full_ready got=%b want=00", {d3_a_ready, d3_b_ready}); end
      end
      if (t == 6) begin
        n_cmp++;
        if (d3_a_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_after_pop got=%b want=1", d3_a_ready); end
      end
      d3_b_valid = 1'b0;
      if (take) begin d3_a_valid = 1'b0; take = 1'b0; end
      if (t == 0) begin
        d3_b_data = 7'h70; d3_b_valid = 1'b1;
        q3.push_back({1'b0, d3_b_data});
      end else if (t <= 4) begin
        d3_a_data = 7'(16 + t - 1); d3_b_data = 7'(32 + t - 1);
        d3_a_valid = 1'b1; d3_b_valid = 1'b1;
        q3.push_back({1'b1, d3_a_data});
        q3.push_back({1'b0, d3_b_data});
      end else if (t == 5) begin
        d3_a_data = 7'h14; d3_a_valid = 1'b1;
        q3.push_back({1'b1, d3_a_data});
      end
      if (t >= 5 && d3_a_valid && d3_a_ready) take = 1'b1;
    end
    n_cmp++; if (n_sb !== 10) begin n_bad++; $display("FAIL fill_count got=%0d want=10", n_sb); end
    n_cmp++; if (q3.size() !== 0) begin n_bad++; $display("FAIL fill_leftover got=%0d want=0", q3.size()); end
  endtask

  task automatic test_gap3();
    logic [7:0] exp;
    int         at[$];
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (d3_sb === 1'b1) begin
        at.push_back(t);
        n_cmp++;
        if (q3.size() == 0) begin
          n_bad++; $display("FAIL gap3_data unexpected strobe got=%h want none", d3_data);
        end else begin
          exp = q3.pop_front();
          if (d3_data !== exp) begin n_bad++; $display("FAIL gap3_data got=%h want=%h", d3_data, exp); end
        end
        n_cmp++; if (d3_data[7] !== 1'b0) begin n_bad++; $display("FAIL gap3_tag got=%b want=0", d3_data[7]); end
      end
      d3_b_valid = 1'b0;
      if (t < 2) begin
        d3_b_data = 7'(49 + t); d3_b_valid = 1'b1;
        q3.push_back({1'b0, d3_b_data});
      end
    end
    n_cmp++;
    if (at.size() != 2) begin
      n_bad++; $display("FAIL gap3_count got=%0d want=2", at.size());
    end else if (at[1] - at[0] !== 4) begin
      n_bad++; $display("FAIL gap3_spacing got=%0d want=4", at[1] - at[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    int         n_sb;
    @(negedge clk);
    d1_a_data = 7'h41; d1_b_data = 7'h42; d1_a_valid = 1'b1; d1_b_valid = 1'b1;
    q1.push_back(8'hC1); q1.push_back(8'h42);
    @(negedge clk);
    d1_a_data = 7'h43; d1_b_data = 7'h44;
    q1.push_back(8'hC3); q1.push_back(8'h44);
    @(negedge clk);
    d1_a_valid = 1'b0; d1_b_valid = 1'b0;
    n_cmp++;
    if (d1_sb !== 1'b1 || q1.size() == 0) begin
      n_bad++; $display("FAIL mid_first_strobe got sb=%b want sb=1", d1_sb);
    end else begin
      exp = q1.pop_front();
      if (d1_data !== exp) begin n_bad++; $display("FAIL mid_first_strobe got=%h want=%h", d1_data, exp); end
    end
    @(negedge clk);
    n_cmp++; if ({d1_sb, d1_busy} !== 2'b01) begin n_bad++; $display("FAIL mid_in_gap got=%b want=01", {d1_sb, d1_busy}); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (d1_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_data got=%h want=00", d1_data); end
    n_cmp++; if ({d1_sb, d1_busy} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_idle got=%b want=00", {d1_sb, d1_busy}); end
    n_cmp++; if ({d1_a_ready, d1_b_ready} !== 2'b11) begin n_bad++; $display("FAIL mid_rst_ready got=%b want=11", {d1_a_ready, d1_b_ready}); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    n_sb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (d1_sb !== 1'b0) n_sb++;
    end
    n_cmp++; if (n_sb !== 0) begin n_bad++; $display("FAIL mid_no_strobe got=%0d want=0", n_sb); end
    n_cmp++; if ({d1_busy, d1_data} !== 9'h000) begin n_bad++; $display("FAIL mid_after got busy=%b data=%h want 0/00", d1_busy, d1_data); end
  endtask

  initial begin
    rst = 1'b1;
    d1_a_data = '0; d1_b_data = '0; d1_a_valid = 1'b0; d1_b_valid = 1'b0;
    d3_a_data = '0; d3_b_data = '0; d3_a_valid = 1'b0; d3_b_valid = 1'b0;
    test_reset();
    test_single();
    test_rr();
    test_fill();
    test_gap3();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
